wb_master_seq: RTL and testbench

- Wishbone classic-cycle initiator: the master-side counterpart of the user-project Wishbone slaves such as the counter block.
- Accepts single or incrementing-burst commands over a valid/ready command port and issues one Wishbone beat at a time.
- Returns one response per beat over a valid/ready response port, with an ack timeout.
- Sits between a local controller (LA-probe sequencer or test driver) and any user-area Wishbone slave.

---
 rtl/wb_master_seq_if.sv | 54 +++++
 rtl/wb_master_seq.sv | 178 +++++++++++++++++
 tb/tb_wb_master_seq.sv | 396 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_master_seq_if.sv
// Bundle of the command port, the response port and the Wishbone initiator
// bus used by wb_master_seq.
//
//   master modport : the sequencer side (drives cmd_ready, wbm_*_o, rsp_*)
//   slave modport  : the environment side, i.e. the local controller plus the
//                    Wishbone slave (drives cmd_*, wbm_dat_i, wbm_ack_i,
//                    rsp_ready)
//
// LEN_W sets the width of cmd_len (beats per command = cmd_len + 1).
interface wb_master_seq_if #(
    parameter int unsigned LEN_W = 4
);
    // Command port
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_we;
    logic [31:0]      cmd_adr;
    logic [31:0]      cmd_dat;
    logic [3:0]       cmd_sel;
    logic [LEN_W-1:0] cmd_len;

    // Wishbone classic initiator
    logic             wbm_cyc_o;
    logic             wbm_stb_o;
    logic             wbm_we_o;
    logic [3:0]       wbm_sel_o;
    logic [31:0]      wbm_adr_o;
    logic [31:0]      wbm_dat_o;
    logic [31:0]      wbm_dat_i;
    logic             wbm_ack_i;

    // Response port
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_dat;
    logic             rsp_err;
    logic             rsp_last;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, cmd_len,
        input  wbm_dat_i, wbm_ack_i, rsp_ready,
        output cmd_ready,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output rsp_valid, rsp_dat, rsp_err, rsp_last
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, cmd_len,
        output wbm_dat_i, wbm_ack_i, rsp_ready,
        input  cmd_ready,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  rsp_valid, rsp_dat, rsp_err, rsp_last
    );
endinterface

// File: rtl/wb_master_seq.sv
// Wishbone classic-cycle initiator. Takes single or incrementing-burst
// commands on a valid/ready command port, issues one Wishbone beat at a time
// with a per-beat ack timeout, and returns one response per beat on a
// valid/ready response port.
//
// Ports:
//   clk   : clock
//   reset : synchronous, active-high reset (dominant, also mid-transfer)
//   bus   : wb_master_seq_if.master (command, Wishbone and response signals)
//   busy  : high whenever the sequencer is not idle
//
// Parameters:
//   TIMEOUT : cycles a beat may wait for ack before it is aborted (1..65535)
//   LEN_W   : width of cmd_len; must match the interface instance
module wb_master_seq #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned LEN_W   = 4
) (
    input  logic            clk,
    input  logic            reset,
    wb_master_seq_if.master bus,
    output logic            busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

    // The counter fires on its TIMEOUT-th waiting cycle, so stb stays high
    // for exactly TIMEOUT cycles on an unanswered beat.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t           state_r;
    logic             we_r;
    logic [31:0]      adr_r;
    logic [31:0]      dat_r;
    logic [3:0]       sel_r;
    logic [LEN_W-1:0] beats_left_r;
    logic [15:0]      tmo_cnt_r;

    logic             cmd_ready_r;
    logic             cyc_r;
    logic             stb_r;
    logic             wbm_we_r;
    logic [3:0]       wbm_sel_r;
    logic [31:0]      wbm_adr_r;
    logic [31:0]      wbm_dat_r;
    logic             rsp_valid_r;
    logic [31:0]      rsp_dat_r;
    logic             rsp_err_r;
    logic             rsp_last_r;
    logic             busy_r;

    // Command/beat sequencer; every bus, response and handshake output is a
    // register written here. Bus qualifiers are zeroed whenever cyc drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            we_r         <= 1'b0;
            adr_r        <= 32'd0;
            dat_r        <= 32'd0;
            sel_r        <= 4'd0;
            beats_left_r <= {LEN_W{1'b0}};
            tmo_cnt_r    <= 16'd0;
            cmd_ready_r  <= 1'b1;
            cyc_r        <= 1'b0;
            stb_r        <= 1'b0;
            wbm_we_r     <= 1'b0;
            wbm_sel_r    <= 4'd0;
            wbm_adr_r    <= 32'd0;
            wbm_dat_r    <= 32'd0;
            rsp_valid_r  <= 1'b0;
            rsp_dat_r    <= 32'd0;
            rsp_err_r    <= 1'b0;
            rsp_last_r   <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.cmd_valid && cmd_ready_r) begin
                        we_r         <= bus.cmd_we;
                        adr_r        <= bus.cmd_adr;
                        dat_r        <= bus.cmd_dat;
                        sel_r        <= bus.cmd_sel;
                        beats_left_r <= bus.cmd_len;
                        tmo_cnt_r    <= 16'd0;
                        cyc_r        <= 1'b1;
                        stb_r        <= 1'b1;
                        wbm_we_r     <= bus.cmd_we;
                        wbm_sel_r    <= bus.cmd_sel;
                        wbm_adr_r    <= bus.cmd_adr;
                        wbm_dat_r    <= bus.cmd_dat;
                        cmd_ready_r  <= 1'b0;
                        busy_r       <= 1'b1;
                        state_r      <= REQ;
                    end
                end
                REQ: begin
                    // Ack is checked first so an ack on the final timeout
                    // cycle still completes the beat normally.
                    if (bus.wbm_ack_i || (tmo_cnt_r == TMO_LAST)) begin
                        rsp_valid_r <= 1'b1;
                        if (bus.wbm_ack_i) begin
                            rsp_dat_r  <= we_r ? 32'd0 : bus.wbm_dat_i;
                            rsp_err_r  <= 1'b0;
                            rsp_last_r <= (beats_left_r == {LEN_W{1'b0}});
                        end else begin
                            // Timed out: abandon the rest of the burst.
                            rsp_dat_r  <= 32'd0;
                            rsp_err_r  <= 1'b1;
                            rsp_last_r <= 1'b1;
                        end
                        cyc_r     <= 1'b0;
                        stb_r     <= 1'b0;
                        wbm_we_r  <= 1'b0;
                        wbm_sel_r <= 4'd0;
                        wbm_adr_r <= 32'd0;
                        wbm_dat_r <= 32'd0;
                        state_r   <= RSP;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 16'd1;
                    end
                end
                RSP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        rsp_dat_r   <= 32'd0;
                        rsp_err_r   <= 1'b0;
                        rsp_last_r  <= 1'b0;
                        if (rsp_last_r) begin
                            cmd_ready_r <= 1'b1;
                            busy_r      <= 1'b0;
                            state_r     <= IDLE;
                        end else begin
                            // Natural 32-bit wrap takes 0xFFFFFFFC to 0.
                            adr_r        <= adr_r + 32'd4;
                            beats_left_r <= beats_left_r - LEN_W'(1'b1);
                            tmo_cnt_r    <= 16'd0;
                            cyc_r        <= 1'b1;
                            stb_r        <= 1'b1;
                            wbm_we_r     <= we_r;
                            wbm_sel_r    <= sel_r;
                            wbm_adr_r    <= adr_r + 32'd4;
                            wbm_dat_r    <= dat_r;
                            state_r      <= REQ;
                        end
                    end
                end
                default: begin
                    cmd_ready_r <= 1'b1;
                    cyc_r       <= 1'b0;
                    stb_r       <= 1'b0;
                    wbm_we_r    <= 1'b0;
                    wbm_sel_r   <= 4'd0;
                    wbm_adr_r   <= 32'd0;
                    wbm_dat_r   <= 32'd0;
                    rsp_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_r;
    assign bus.wbm_cyc_o = cyc_r;
    assign bus.wbm_stb_o = stb_r;
    assign bus.wbm_we_o  = wbm_we_r;
    assign bus.wbm_sel_o = wbm_sel_r;
    assign bus.wbm_adr_o = wbm_adr_r;
    assign bus.wbm_dat_o = wbm_dat_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_dat   = rsp_dat_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.rsp_last  = rsp_last_r;
    assign busy          = busy_r;
endmodule

// File: tb/tb_wb_master_seq.sv
// Self-checking bench for wb_master_seq: directed scenarios followed by
// randomized commands, Wishbone ack delays and response backpressure, all
// compared every cycle against a transaction-level model of the sequencer.
module tb_wb_master_seq;
    localparam int unsigned TMO   = 8;
    localparam int unsigned LEN_W = 4;
    localparam logic [31:0] RD_KEY = 32'h55AA55AA;

    logic clk;
    logic reset;
    logic busy;

    wb_master_seq_if #(.LEN_W(LEN_W)) bus ();

    wb_master_seq #(.TIMEOUT(TMO), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 60) $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } beat_t;

    beat_t       m_beats[$];       // beats of the current command still to issue
    bit          m_active = 1'b0;  // a command is in progress
    bit          m_stb = 1'b0;     // a beat should be on the bus this cycle
    int          m_stb_cnt = 0;
    bit          m_rsp_pending = 1'b0;
    logic [31:0] m_rsp_dat = 32'd0;
    logic        m_rsp_err = 1'b0;
    logic        m_rsp_last = 1'b0;
    bit          m_reset_seen = 1'b1;

    // Observation log used by the directed literal checks
    int          o_stb_cycles = 0;
    int          o_stb_rises = 0;
    bit          o_prev_stb = 1'b0;
    int          o_run = 0;
    int          o_run_max = 0;
    logic [31:0] o_adr_log[$];
    logic [33:0] o_rsp_log[$];

    always @(negedge clk) begin
        if (m_reset_seen) begin
            chk("rst_cyc", bus.wbm_cyc_o, 0);
            chk("rst_stb", bus.wbm_stb_o, 0);
            chk("rst_we", bus.wbm_we_o, 0);
            chk("rst_sel", bus.wbm_sel_o, 0);
            chk("rst_adr", bus.wbm_adr_o, 0);
            chk("rst_dat", bus.wbm_dat_o, 0);
            chk("rst_rsp_valid", bus.rsp_valid, 0);
            chk("rst_rsp_dat", bus.rsp_dat, 0);
            chk("rst_rsp_err", bus.rsp_err, 0);
            chk("rst_rsp_last", bus.rsp_last, 0);
            chk("rst_cmd_ready", bus.cmd_ready, 1);
            chk("rst_busy", busy, 0);
        end else begin
            if (m_rsp_pending) begin
                chk("rsp_valid", bus.rsp_valid, 1);
                chk("rsp_dat", bus.rsp_dat, m_rsp_dat);
                chk("rsp_err", bus.rsp_err, m_rsp_err);
                chk("rsp_last", bus.rsp_last, m_rsp_last);
            end else begin
                chk("rsp_valid_idle", bus.rsp_valid, 0);
            end
            if (m_stb) begin
                chk("stb", bus.wbm_stb_o, 1);
                chk("cyc", bus.wbm_cyc_o, 1);
                chk("we", bus.wbm_we_o, m_beats[0].we);
                chk("sel", bus.wbm_sel_o, m_beats[0].sel);
                chk("adr", bus.wbm_adr_o, m_beats[0].adr);
                chk("wdat", bus.wbm_dat_o, m_beats[0].dat);
            end else begin
                chk("stb_low", bus.wbm_stb_o, 0);
                chk("cyc_low", bus.wbm_cyc_o, 0);
                chk("we_zero", bus.wbm_we_o, 0);
                chk("sel_zero", bus.wbm_sel_o, 0);
                chk("adr_zero", bus.wbm_adr_o, 0);
                chk("wdat_zero", bus.wbm_dat_o, 0);
            end
            chk("cmd_ready", bus.cmd_ready, !m_active);
            chk("busy", busy, m_active);
        end

        // observation log
        if (bus.wbm_stb_o) begin
            o_stb_cycles++;
            if (!o_prev_stb) begin
                o_stb_rises++;
                o_adr_log.push_back(bus.wbm_adr_o);
            end
        end
        o_prev_stb = bus.wbm_stb_o;
        if (bus.rsp_valid) begin
            o_run++;
            if (o_run > o_run_max) o_run_max = o_run;
        end else begin
            o_run = 0;
        end
        if (bus.rsp_valid && bus.rsp_ready && !reset)
            o_rsp_log.push_back({bus.rsp_dat, bus.rsp_err, bus.rsp_last});

        // predict what the coming clock edge produces
        if (reset) begin
            m_beats.delete();
            m_active = 1'b0;
            m_stb = 1'b0;
            m_stb_cnt = 0;
            m_rsp_pending = 1'b0;
            m_reset_seen = 1'b1;
        end else begin
            m_reset_seen = 1'b0;
            if (!m_active) begin
                if (bus.cmd_valid) begin
                    for (int i = 0; i <= int'(bus.cmd_len); i++)
                        m_beats.push_back('{we: bus.cmd_we, adr: bus.cmd_adr + 32'(4 * i),
                                            dat: bus.cmd_dat, sel: bus.cmd_sel});
                    m_active = 1'b1;
                    m_stb = 1'b1;
                    m_stb_cnt = 0;
                end
            end else if (m_stb) begin
                m_stb_cnt++;
                if (bus.wbm_ack_i) begin
                    m_rsp_dat = m_beats[0].we ? 32'd0 : (m_beats[0].adr ^ RD_KEY);
                    m_rsp_err = 1'b0;
                    m_rsp_last = (m_beats.size() == 1);
                    void'(m_beats.pop_front());
                    m_stb = 1'b0;
                    m_rsp_pending = 1'b1;
                end else if (m_stb_cnt == int'(TMO)) begin
                    m_rsp_dat = 32'd0;
                    m_rsp_err = 1'b1;
                    m_rsp_last = 1'b1;
                    m_beats.delete();
                    m_stb = 1'b0;
                    m_rsp_pending = 1'b1;
                end
            end else if (m_rsp_pending && bus.rsp_ready) begin
                m_rsp_pending = 1'b0;
                if (m_rsp_last) begin
                    m_active = 1'b0;
                end else begin
                    m_stb = 1'b1;
                    m_stb_cnt = 0;
                end
            end
        end
    end

    // ---------------- Wishbone slave and response consumer ----------------
    int fixed_delay = 1;   // <0 selects random ack delays
    bit spur_en = 1'b0;    // random acks while stb is low
    bit rr_random = 1'b0;  // random rsp_ready
    int rsp_hold = 0;      // cycles to hold rsp_ready low on the next response

    function automatic int pick_delay();
        int r;
        if (fixed_delay >= 0) return fixed_delay;
        r = int'($urandom_range(0, 9));
        if (r == 0) return 100;            // never acks: timeout
        if (r == 1) return int'(TMO) - 1;  // ack on the final timeout cycle
        return int'($urandom_range(0, 3));
    endfunction

    initial begin
        int wcnt;
        int cur_delay;
        wcnt = 0;
        cur_delay = 0;
        bus.wbm_ack_i = 1'b0;
        bus.wbm_dat_i = 32'd0;
        bus.rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                bus.wbm_ack_i = 1'b0;
                wcnt = 0;
            end else if (bus.wbm_stb_o) begin
                if (wcnt == 0) cur_delay = pick_delay();
                if (wcnt >= cur_delay) begin
                    bus.wbm_ack_i = 1'b1;
                    bus.wbm_dat_i = bus.wbm_adr_o ^ RD_KEY;
                end else begin
                    bus.wbm_ack_i = 1'b0;
                    bus.wbm_dat_i = $urandom;
                end
                wcnt++;
            end else begin
                wcnt = 0;
                bus.wbm_ack_i = spur_en && ($urandom_range(0, 3) == 0);
                bus.wbm_dat_i = $urandom;
            end
            if (rsp_hold > 0 && bus.rsp_valid) begin
                bus.rsp_ready = 1'b0;
                rsp_hold--;
            end else if (rr_random) begin
                bus.rsp_ready = 1'($urandom_range(0, 1));
            end else begin
                bus.rsp_ready = 1'b1;
            end
        end
    end

    // ---------------- command driver ----------------
    task automatic clear_obs();
        o_stb_cycles = 0;
        o_stb_rises = 0;
        o_run_max = 0;
        o_adr_log.delete();
        o_rsp_log.delete();
    endtask

    task automatic run_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic [LEN_W-1:0] len);
        int n;
        bit ok;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_we = we;
        bus.cmd_adr = adr;
        bus.cmd_dat = dat;
        bus.cmd_sel = sel;
        bus.cmd_len = len;
        n = 0;
        ok = 1'b0;
        do begin
            @(negedge clk);
            ok = bus.cmd_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 100);
        bus.cmd_valid = 1'b0;
        bus.cmd_we = 1'($urandom);
        bus.cmd_adr = $urandom;
        bus.cmd_dat = $urandom;
        bus.cmd_len = LEN_W'($urandom);
        chk("cmd_accepted", ok, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 3000);
        chk("idle_reached", busy, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_we = 1'b0;
        bus.cmd_adr = 32'd0;
        bus.cmd_dat = 32'd0;
        bus.cmd_sel = 4'd0;
        bus.cmd_len = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single write, ack after 2 wait cycles
        fixed_delay = 2;
        clear_obs();
        run_cmd(1'b1, 32'h30000000, 32'hDEADBEEF, 4'hF, 4'd0);
        wait_idle();
        chk("wr1_stb_rises", 64'(o_stb_rises), 1);
        chk("wr1_stb_cycles", 64'(o_stb_cycles), 3);
        chk("wr1_adr", o_adr_log[0], 32'h30000000);
        chk("wr1_rsp_count", 64'(o_rsp_log.size()), 1);
        chk("wr1_rsp", o_rsp_log[0], {32'h0, 1'b0, 1'b1});

        // Read burst of 4 from 0x30000010, rsp_ready high
        fixed_delay = 0;
        clear_obs();
        run_cmd(1'b0, 32'h30000010, 32'h0, 4'hF, 4'd3);
        wait_idle();
        chk("rd4_rsp_count", 64'(o_rsp_log.size()), 4);
        chk("rd4_adr3", o_adr_log[3], 32'h3000001C);
        chk("rd4_rsp0", o_rsp_log[0], {32'h65AA55BA, 1'b0, 1'b0});
        chk("rd4_rsp2", o_rsp_log[2], {32'h65AA55B2, 1'b0, 1'b0});
        chk("rd4_rsp3", o_rsp_log[3], {32'h65AA55B6, 1'b0, 1'b1});

        // Backpressure on the first of two responses
        fixed_delay = 1;
        rsp_hold = 5;
        clear_obs();
        run_cmd(1'b0, 32'h30000040, 32'h12345678, 4'h3, 4'd1);
        wait_idle();
        chk("bp_rsp_valid_run", 64'(o_run_max), 6);
        chk("bp_stb_rises", 64'(o_stb_rises), 2);

        // Timeout: slave never acks
        fixed_delay = 100;
        clear_obs();
        run_cmd(1'b0, 32'h30000080, 32'h0, 4'hF, 4'd2);
        wait_idle();
        chk("tmo_stb_cycles", 64'(o_stb_cycles), 8);
        chk("tmo_stb_rises", 64'(o_stb_rises), 1);
        chk("tmo_rsp_count", 64'(o_rsp_log.size()), 1);
        chk("tmo_rsp", o_rsp_log[0], {32'h0, 1'b1, 1'b1});

        // Address wrap with ack on the final timeout cycle
        fixed_delay = int'(TMO) - 1;
        clear_obs();
        run_cmd(1'b0, 32'hFFFFFFFC, 32'h0, 4'hF, 4'd1);
        wait_idle();
        chk("wrap_adr1", o_adr_log[1], 32'h00000000);
        chk("wrap_rsp0", o_rsp_log[0], {32'hAA55AA56, 1'b0, 1'b0});
        chk("wrap_rsp1", o_rsp_log[1], {32'h55AA55AA, 1'b0, 1'b1});

        // Reset during beat 2 of 4
        fixed_delay = 2;
        clear_obs();
        run_cmd(1'b0, 32'h30000100, 32'h0, 4'hF, 4'd3);
        begin
            int n;
            n = 0;
            while (o_stb_rises < 2 && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("rst_beat2_seen", 64'(o_stb_rises), 2);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_cyc", bus.wbm_cyc_o, 0);
        chk("midrst_stb", bus.wbm_stb_o, 0);
        chk("midrst_rsp_valid", bus.rsp_valid, 0);
        chk("midrst_cmd_ready", bus.cmd_ready, 1);
        chk("midrst_rsp_count", 64'(o_rsp_log.size()), 1);
        clear_obs();
        run_cmd(1'b1, 32'h30000200, 32'hCAFEF00D, 4'h5, 4'd1);
        wait_idle();
        chk("postrst_rsp_count", 64'(o_rsp_log.size()), 2);
        chk("postrst_rsp1", o_rsp_log[1], {32'h0, 1'b0, 1'b1});

        // Randomized commands, delays, backpressure and spurious acks
        fixed_delay = -1;
        spur_en = 1'b1;
        rr_random = 1'b1;
        for (int k = 0; k < 40; k++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 4) == 0) ? 32'hFFFFFFF0 : ($urandom & 32'hFFFFFFFC);
            run_cmd(1'($urandom), a, $urandom, 4'($urandom), LEN_W'($urandom));
            wait_idle();
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        spur_en = 1'b0;
        rr_random = 1'b0;
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
